// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
//  Module      : flash_loader
//  Description : Collects a byte stream into N-bit little-endian words and
//                writes WORDS words per frame to a storage block, one
//                registered write strobe per word, then pulses frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_loader #(
   parameter int N     = 16,
   parameter int WORDS = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_abort,
   input  logic [7:0]   i_byte,
   input  logic         i_byte_valid,
   output logic         o_byte_ready,
   output logic [N-1:0] o_word,
   output logic         o_write_enable,
   output logic [1:0]   o_address,
   output logic         o_busy,
   output logic         o_frame_done
);

   localparam int BYTES = N / 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     idx_q, idx_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [N-1:0]   word_q, word_d;
   logic [1:0]     addr_q, addr_d;
   logic           we_q, we_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   // State, datapath and output registers; outputs are decoded from the next
   // state so they line up exactly with the state they describe.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 2'd0;
         word_q  <= '0;
         addr_q  <= 2'd0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, byte assembly and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      addr_d  = addr_q;

      case (state_q)
         S_IDLE: begin
            // Ready is low here, so a byte presented alongside start is dropped.
            if (i_start) begin
               state_d = S_COLLECT;
               idx_d   = 2'd0;
               cnt_d   = 2'd0;
            end
         end
         S_COLLECT: begin
            if (i_abort) begin
               // Abort wins over a byte offered in the same cycle.
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 2'd0;
            end else if (i_byte_valid && ready_q) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (cnt_q == 2'(b)) begin
                     word_d[b*8 +: 8] = i_byte;
                  end
               end
               if (cnt_q == 2'(BYTES - 1)) begin
                  state_d = S_WRITE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         S_WRITE: begin
            // The strobe of this cycle is already on the pins; abort only
            // stops what would follow it.
            if (i_abort) begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 2'd0;
            end else if (idx_q == 2'(WORDS - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_COLLECT;
               idx_d   = idx_q + 2'd1;
               cnt_d   = 2'd0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 2'd0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 2'd0;
         end
      endcase

      // Address only moves when a write is about to be issued.
      if (state_d == S_WRITE) begin
         addr_d = idx_d;
      end

      we_d    = (state_d == S_WRITE);
      ready_d = (state_d == S_COLLECT);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   assign o_byte_ready   = ready_q;
   assign o_word         = word_q;
   assign o_write_enable = we_q;
   assign o_address      = addr_q;
   assign o_busy         = busy_q;
   assign o_frame_done   = done_q;

endmodule
`default_nettype wire

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter N, default 16: word width in bits; legal values are multiples of 8 from 8 to 32.
REQ-002 SHALL have parameter WORDS, default 4: words per frame; address width is 2 bits, so WORDS is at most 4.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  arms loading of one frame.
REQ-006 SHALL have port i_abort  input  1  cancels the frame in progress.
REQ-007 SHALL have port i_byte  input  8  incoming data byte.
REQ-008 SHALL have port i_byte_valid  input  1  i_byte is valid this cycle.
REQ-009 SHALL have port o_byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port o_word  output  N  assembled word to the storage block.
REQ-011 SHALL have port o_write_enable  output  1  one-cycle write strobe to the storage block.
REQ-012 SHALL have port o_address  output  2  storage address for the write.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse after the final word is written.

Function
REQ-015 SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE, with all outputs registered.
REQ-016 IDLE: o_byte_ready=0; on i_start=1, go to COLLECT with word index=0 and byte count=0.
REQ-017 COLLECT: o_byte_ready=1; a byte is accepted only when i_byte_valid=1 and o_byte_ready=1 in the same cycle.
REQ-018 SHALL assemble bytes little-endian: the first accepted byte goes to bits [7:0], the next to [15:8], and so on.
REQ-019 On acceptance of byte N/8 of a word, SHALL go to WRITE in the next cycle; the last accepted byte is visible in o_word in that WRITE cycle (write at t+1 for the last byte accepted at t).
REQ-020 WRITE: o_write_enable=1 for exactly one cycle; o_address=word index; o_word stable; o_byte_ready=0.
REQ-021 After WRITE, if word index < WORDS-1: increment the index, clear the byte count, return to COLLECT.
REQ-022 After WRITE, if word index = WORDS-1: go to DONE.
REQ-023 DONE: o_frame_done=1 for one cycle, then go to IDLE with word index back at 0.
REQ-024 o_write_enable SHALL be 0 in every state other than WRITE; o_address SHALL hold its last value outside WRITE.
REQ-025 i_start SHALL be ignored while o_busy=1.
REQ-026 When i_start and i_byte_valid are both 1 in IDLE, the byte SHALL NOT be accepted (ready is low in IDLE).
REQ-027 i_abort=1 in COLLECT or WRITE SHALL force IDLE next cycle: the partial word is discarded, no further write occurs, and no frame_done is issued; a write strobe already asserted that cycle still completes.
REQ-028 i_abort has priority over byte acceptance in the same cycle; i_abort in IDLE or DONE has no effect.
REQ-029 Gaps in i_byte_valid SHALL be tolerated indefinitely; there is no timeout.

Reset
REQ-030 When i_rst_n=0 at a clock edge, the FSM SHALL enter IDLE with word index=0 and byte count=0.
REQ-031 Reset values SHALL be: o_word=0, o_address=0, o_write_enable=0, o_byte_ready=0, o_busy=0, o_frame_done=0.
REQ-032 Reset mid-frame SHALL discard partial data and SHALL NOT produce a write strobe in the cycle after reset.

Verification
REQ-033 Full frame: start, then bytes 34 12 78 56 BC 9A F0 DE -> four strobes writing addr0=1234, addr1=5678, addr2=9ABC, addr3=DEF0, then one frame_done pulse and busy=0.
REQ-034 Gapped valid: same bytes with 3 idle cycles between each -> identical writes; each strobe comes 1 cycle after its high byte is accepted.
REQ-035 Abort: start, bytes 11 22 33, abort -> one write (addr0=2211), no frame_done; a new start plus 8 bytes writes from addr0 again.
REQ-036 Reset mid-frame: i_rst_n=0 after 5 bytes -> all outputs at reset values, and no strobe in the following cycle.
REQ-037 Start while busy: pulse i_start during COLLECT -> no restart; the address sequence continues 0,1,2,3 unchanged.
REQ-038 Start with valid in IDLE: i_start and i_byte_valid=1 with byte AA in the same cycle -> byte AA is not captured; the first word is formed from the next two bytes.
